traffic_phase_ctrl: RTL and testbench

- Sequences one car/pedestrian crossing through a fixed phase ring: car green, car yellow, all-red clearance, pedestrian green, pedestrian flashing, all-red clearance.
- Timing is in whole seconds, counted on an external 1 Hz `tick` pulse.
- A debounced pedestrian button request shortens the car-green phase.
- Drives the lamp outputs plus a seconds-remaining value for the 7-segment display path, and sits between the key filter / 1 Hz divider and the display mux.

---
 rtl/traffic_phase_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: phase sequencer for one car/pedestrian crossing.
// Ring: car green -> car yellow -> clear -> ped green -> ped flash -> clear.
// Timing is counted in whole seconds on an external 1 Hz tick strobe.
// A pending pedestrian request shortens the car-green phase to PED_CUT seconds.
// Optional build macro TRAFFIC_NIGHT_MODE_EN adds the `night` input and the
// NIGHT state (code 6), which flashes the car yellow lamp.
module traffic_phase_ctrl #(
  parameter int T_GREEN  = 30,
  parameter int T_YELLOW = 3,
  parameter int T_CLEAR  = 2,
  parameter int T_PED    = 15,
  parameter int T_FLASH  = 5,
  parameter int PED_CUT  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       enable,
  input  logic       ped_req,
`ifdef TRAFFIC_NIGHT_MODE_EN
  input  logic       night,
`endif
  output logic [2:0] car_led,
  output logic [1:0] people_led,
  output logic [5:0] remain,
  output logic [2:0] phase,
  output logic       ped_pending
);

  typedef enum logic [2:0] {
    CAR_GREEN  = 3'd0,
    CAR_YELLOW = 3'd1,
    CLEAR1     = 3'd2,
    PED_GREEN  = 3'd3,
    PED_FLASH  = 3'd4,
    CLEAR2     = 3'd5
`ifdef TRAFFIC_NIGHT_MODE_EN
    ,
    NIGHT      = 3'd6
`endif
  } phase_e;

  localparam logic [5:0] T_GREEN_L  = 6'(T_GREEN);
  localparam logic [5:0] T_YELLOW_L = 6'(T_YELLOW);
  localparam logic [5:0] T_CLEAR_L  = 6'(T_CLEAR);
  localparam logic [5:0] T_PED_L    = 6'(T_PED);
  localparam logic [5:0] T_FLASH_L  = 6'(T_FLASH);
  localparam logic [5:0] PED_CUT_L  = 6'(PED_CUT);

  // Car lamps {red, green, yellow} for a given phase and flash level.
  function automatic logic [2:0] car_lamp(input phase_e p, input logic f);
    logic [2:0] v;
    case (p)
      CAR_GREEN:  v = 3'b010;
      CAR_YELLOW: v = 3'b001;
`ifdef TRAFFIC_NIGHT_MODE_EN
      NIGHT:      v = {2'b00, f};
`endif
      default:    v = 3'b100;
    endcase
    return v;
  endfunction

  // Pedestrian lamps {red, green} for a given phase and flash level.
  function automatic logic [1:0] ped_lamp(input phase_e p, input logic f);
    logic [1:0] v;
    case (p)
      PED_GREEN:  v = 2'b01;
      PED_FLASH:  v = {1'b0, f};
`ifdef TRAFFIC_NIGHT_MODE_EN
      NIGHT:      v = 2'b00;
`endif
      default:    v = 2'b10;
    endcase
    return v;
  endfunction

  phase_e     state_r;
  phase_e     state_nx_s;
  logic [5:0] remain_r;
  logic [5:0] remain_nx_s;
  logic       flash_r;
  logic       flash_nx_s;
  logic       pend_r;
  logic       pend_nx_s;
  logic [2:0] car_led_r;
  logic [1:0] people_led_r;
  logic       adv_s;

  assign adv_s       = tick & enable;
  assign phase       = state_r;
  assign remain      = remain_r;
  assign ped_pending = pend_r;
  assign car_led     = car_led_r;
  assign people_led  = people_led_r;

  // Next-state, seconds counter, flash and request-latch computation.
  always_comb begin
    state_nx_s  = state_r;
    remain_nx_s = remain_r;
    flash_nx_s  = flash_r;
    pend_nx_s   = pend_r;

    // A request is latched everywhere except while pedestrians already walk.
    if (ped_req && (state_r != PED_GREEN)) begin
      pend_nx_s = 1'b1;
    end else begin
      pend_nx_s = pend_r;
    end

    case (state_r)
      CAR_GREEN: begin
`ifdef TRAFFIC_NIGHT_MODE_EN
        if (adv_s && night) begin
          state_nx_s  = NIGHT;
          remain_nx_s = 6'd0;
          pend_nx_s   = 1'b0;
        end else
`endif
        // The clamp needs no tick and beats a same-cycle decrement.
        if (pend_r && (remain_r > PED_CUT_L)) begin
          remain_nx_s = PED_CUT_L;
        end else if (adv_s) begin
          if (remain_r > 6'd1) begin
            remain_nx_s = remain_r - 6'd1;
          end else begin
            state_nx_s  = CAR_YELLOW;
            remain_nx_s = T_YELLOW_L;
          end
        end else begin
          remain_nx_s = remain_r;
        end
      end

      CAR_YELLOW: begin
        if (adv_s) begin
          if (remain_r > 6'd1) begin
            remain_nx_s = remain_r - 6'd1;
          end else begin
            state_nx_s  = CLEAR1;
            remain_nx_s = T_CLEAR_L;
          end
        end else begin
          remain_nx_s = remain_r;
        end
      end

      CLEAR1: begin
        if (adv_s) begin
          if (remain_r > 6'd1) begin
            remain_nx_s = remain_r - 6'd1;
          end else begin
            // Entering ped green serves the request; a same-edge press is lost.
            state_nx_s  = PED_GREEN;
            remain_nx_s = T_PED_L;
            pend_nx_s   = 1'b0;
          end
        end else begin
          remain_nx_s = remain_r;
        end
      end

      PED_GREEN: begin
        if (adv_s) begin
          if (remain_r > 6'd1) begin
            remain_nx_s = remain_r - 6'd1;
          end else begin
            state_nx_s  = PED_FLASH;
            remain_nx_s = T_FLASH_L;
            flash_nx_s  = 1'b1;
          end
        end else begin
          remain_nx_s = remain_r;
        end
      end

      PED_FLASH: begin
        if (adv_s) begin
          if (remain_r > 6'd1) begin
            remain_nx_s = remain_r - 6'd1;
            flash_nx_s  = ~flash_r;
          end else begin
            state_nx_s  = CLEAR2;
            remain_nx_s = T_CLEAR_L;
          end
        end else begin
          remain_nx_s = remain_r;
        end
      end

      CLEAR2: begin
        if (adv_s) begin
          if (remain_r > 6'd1) begin
            remain_nx_s = remain_r - 6'd1;
          end else begin
            state_nx_s  = CAR_GREEN;
            remain_nx_s = T_GREEN_L;
          end
        end else begin
          remain_nx_s = remain_r;
        end
      end

`ifdef TRAFFIC_NIGHT_MODE_EN
      NIGHT: begin
        pend_nx_s = 1'b0;
        if (adv_s) begin
          if (!night) begin
            state_nx_s  = CLEAR2;
            remain_nx_s = T_CLEAR_L;
          end else begin
            flash_nx_s = ~flash_r;
          end
        end else begin
          flash_nx_s = flash_r;
        end
      end
`endif

      default: begin
        // Unused encodings recover into a fresh car-green phase.
        state_nx_s  = CAR_GREEN;
        remain_nx_s = T_GREEN_L;
      end
    endcase
  end

  // Phase state, counter, flash and request registers with async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= CAR_GREEN;
      remain_r <= T_GREEN_L;
      flash_r  <= 1'b1;
      pend_r   <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      remain_r <= remain_nx_s;
      flash_r  <= flash_nx_s;
      pend_r   <= pend_nx_s;
    end
  end

  // Lamp registers decoded from the next state so they track state_r exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      car_led_r    <= 3'b010;
      people_led_r <= 2'b10;
    end else begin
      car_led_r    <= car_lamp(state_nx_s, flash_nx_s);
      people_led_r <= ped_lamp(state_nx_s, flash_nx_s);
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: directed phase-ring scenarios
// followed by randomized stimulus, all compared against a seconds-level
// reference model of the crossing.
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       enable;
  logic       ped_req;
`ifdef TRAFFIC_NIGHT_MODE_EN
  logic       night;
`endif
  logic [2:0] car_led;
  logic [1:0] people_led;
  logic [5:0] remain;
  logic [2:0] phase;
  logic       ped_pending;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: phase number, seconds left, flash level, pending request.
  int m_phase;
  int m_remain;
  int m_flash;
  int m_pend;
  int dur [6] = '{30, 3, 2, 15, 5, 2};

  always #5 clk = ~clk;

  traffic_phase_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .enable     (enable),
    .ped_req    (ped_req),
`ifdef TRAFFIC_NIGHT_MODE_EN
    .night      (night),
`endif
    .car_led    (car_led),
    .people_led (people_led),
    .remain     (remain),
    .phase      (phase),
    .ped_pending(ped_pending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int exp_car();
    if (m_phase == 0) return 2;       // 010
    else if (m_phase == 1) return 1;  // 001
    else if (m_phase == 6) return m_flash;
    else return 4;                    // 100
  endfunction

  function automatic int exp_ped();
    if (m_phase == 3) return 1;       // 01
    else if (m_phase == 4) return m_flash;
    else if (m_phase == 6) return 0;
    else return 2;                    // 10
  endfunction

  task automatic compare_all();
    check("phase", phase, m_phase);
    check("remain", remain, m_remain);
    check("car_led", car_led, exp_car());
    check("people_led", people_led, exp_ped());
    check("ped_pending", ped_pending, m_pend);
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_remain = dur[0];
    m_flash  = 1;
    m_pend   = 0;
  endtask

  // One clock edge of crossing behaviour, expressed in seconds and phases.
  task automatic model_step(input bit t, input bit p, input bit e, input bit n);
    bit adv;
    int np;
    adv = t && e;
    np  = (p && m_phase != 3 && m_phase != 6) ? 1 : m_pend;
    if (m_phase == 6) begin
      np = 0;
      if (adv) begin
        if (!n) begin
          m_phase  = 5;
          m_remain = dur[5];
        end else begin
          m_flash = 1 - m_flash;
        end
      end
    end else if (m_phase == 0 && adv && n) begin
      m_phase  = 6;
      m_remain = 0;
      np       = 0;
    end else if (m_phase == 0 && m_pend == 1 && m_remain > 5) begin
      m_remain = 5;
    end else if (adv) begin
      if (m_remain > 1) begin
        m_remain = m_remain - 1;
        if (m_phase == 4) m_flash = 1 - m_flash;
      end else begin
        m_phase  = (m_phase + 1) % 6;
        m_remain = dur[m_phase];
        if (m_phase == 4) m_flash = 1;
        if (m_phase == 3) np = 0;
      end
    end
    m_pend = np;
  endtask

  // Drive one clock cycle, advance the model, then compare after the edge.
  task automatic cyc(input bit t, input bit p, input bit e);
    tick    = t;
    ped_req = p;
    enable  = e;
    @(posedge clk);
`ifdef TRAFFIC_NIGHT_MODE_EN
    model_step(t, p, e, night);
`else
    model_step(t, p, e, 1'b0);
`endif
    #1;
    compare_all();
    tick    = 1'b0;
    ped_req = 1'b0;
  endtask

  task automatic idle(input int n, input bit e);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, e);
  endtask

  // One second: nine quiet clocks followed by a tick clock.
  task automatic tk(input bit e);
    idle(9, e);
    cyc(1'b1, 1'b0, e);
  endtask

  // Advance whole seconds until the model reaches the given phase/remain.
  task automatic run_to(input int ph, input int rem);
    int guard;
    guard = 0;
    while (!(m_phase == ph && m_remain == rem) && guard < 400) begin
      tk(1'b1);
      guard++;
    end
    check("run_to_reached", (m_phase == ph && m_remain == rem) ? 1 : 0, 1);
  endtask

  initial begin
    rst     = 1'b1;
    tick    = 1'b0;
    enable  = 1'b1;
    ped_req = 1'b0;
`ifdef TRAFFIC_NIGHT_MODE_EN
    night   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    compare_all();
    check("reset_car", car_led, 3'b010);
    check("reset_remain", remain, 30);
    #3 rst = 1'b0;

    // Full ring without requests: 30+3+2+15+5+2 seconds.
    repeat (57) tk(1'b1);
    check("ring_back_phase", phase, 0);
    check("ring_back_remain", remain, 30);

    // Request at remain=20: latched, then clamped to PED_CUT.
    run_to(0, 20);
    cyc(1'b0, 1'b1, 1'b1);
    check("req_latched", ped_pending, 1);
    cyc(1'b0, 1'b0, 1'b1);
    check("clamp_remain", remain, 5);
    repeat (5) tk(1'b1);
    check("yellow_after_clamp", phase, 1);
    run_to(3, 15);
    check("pending_served", ped_pending, 0);

    // Request during ped green is ignored.
    cyc(1'b0, 1'b1, 1'b1);
    check("ped_green_ignore", ped_pending, 0);

    // Flash pattern through PED_FLASH and into CLEAR2.
    run_to(4, 5);
    check("flash_entry", people_led, 2'b01);
    for (int i = 0; i < 4; i++) begin
      tk(1'b1);
      check("flash_seq", people_led, (i % 2 == 0) ? 0 : 1);
    end
    tk(1'b1);
    check("clear2_people", people_led, 2'b10);
    check("clear2_phase", phase, 5);

    // Request in CLEAR2 carries into and clamps the next green.
    cyc(1'b0, 1'b1, 1'b1);
    check("clear2_req", ped_pending, 1);
    run_to(0, 30);
    cyc(1'b0, 1'b0, 1'b1);
    check("carry_clamp", remain, 5);

    // Request at remain=3 does not clamp.
    run_to(1, 3);
    run_to(0, 3);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    check("no_clamp_remain", remain, 3);

    // Freeze in yellow with remain=2 for 20 ticks.
    run_to(1, 2);
    repeat (20) begin
      idle(9, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
    end
    check("freeze_phase", phase, 1);
    check("freeze_remain", remain, 2);
    tk(1'b1);
    tk(1'b1);
    check("unfreeze_clear1", phase, 2);

    // Asynchronous reset in the middle of ped green.
    run_to(3, 10);
    idle(3, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("async_rst_people", people_led, 2'b10);
    #1 rst = 1'b0;

`ifdef TRAFFIC_NIGHT_MODE_EN
    // Night mode: enter from green, flash yellow, exit via CLEAR2.
    night = 1'b1;
    tk(1'b1);
    check("night_phase", phase, 6);
    check("night_remain", remain, 0);
    tk(1'b1);
    tk(1'b1);
    night = 1'b0;
    tk(1'b1);
    check("night_exit", phase, 5);
    tk(1'b1);
    tk(1'b1);
    check("night_resume", phase, 0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
`ifdef TRAFFIC_NIGHT_MODE_EN
      if ($urandom_range(0, 63) == 0) night = ~night;
`endif
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 7) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
